// File: rtl/cart_mapper.sv
// Cartridge bank mapper: decodes CPU writes into banking control registers
// and translates CPU addresses into physical ROM/RAM addresses.
module cart_mapper #(
    parameter  int unsigned ROM_BANKS = 32,
    parameter  int unsigned RAM_BANKS = 4,
    localparam int unsigned ROM_BW    = $clog2(ROM_BANKS),
    localparam int unsigned ROM_AW    = ROM_BW + 14,
    localparam int unsigned RAM_BW    = (RAM_BANKS > 1) ? $clog2(RAM_BANKS) : 1,
    localparam int unsigned RAM_AW    = RAM_BW + 13
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [15:0]       A,
    input  logic [7:0]        Do,
    input  logic              wr_n,
    input  logic              rd_n,
    input  logic              cs_n,
    input  logic [7:0]        rom_data,
    input  logic [7:0]        ram_data,
    output logic [7:0]        Di,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_cs,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_we
);

    localparam logic HAS_RAM   = (RAM_BANKS > 0);
    localparam logic MULTI_RAM = (RAM_BANKS > 1);

    logic       wr_act;
    logic       rd_act;
    logic       commit;
    logic       wr_q;
    logic       ram_en;
    logic [4:0] bank_lo;
    logic [1:0] bank_hi;
    logic       mode;
    logic [4:0] eff_lo;
    logic [6:0] rom_bank;
    logic [RAM_BW-1:0] ram_bank;
    logic       ram_range;
    logic       unused_do;

    assign wr_act = !cs_n && !wr_n;
    assign rd_act = !cs_n && !rd_n;
    // A write strobe held for several cycles commits only on its first edge.
    assign commit = wr_act && !wr_q;
    assign unused_do = ^Do[7:5];

    // Control registers, updated once per write strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= 1'b0;
            ram_en  <= 1'b0;
            bank_lo <= 5'd0;
            bank_hi <= 2'd0;
            mode    <= 1'b0;
        end else begin
            wr_q <= wr_act;
            if (commit) begin
                case (A[15:13])
                    3'd0:    ram_en  <= (Do[3:0] == 4'hA);
                    3'd1:    bank_lo <= Do[4:0];
                    3'd2:    bank_hi <= Do[1:0];
                    3'd3:    mode    <= Do[0];
                    default: ;
                endcase
            end
        end
    end

    // Address translation and read-data steering, zero-cycle latency.
    always_comb begin
        eff_lo    = (bank_lo == 5'd0) ? 5'd1 : bank_lo;
        rom_bank  = 7'd0;
        ram_bank  = '0;
        ram_range = (A[15:13] == 3'b101);

        if (A[14]) begin
            rom_bank = {bank_hi, eff_lo};
        end else if (mode) begin
            rom_bank = {bank_hi, 5'd0};
        end

        if (MULTI_RAM && mode) begin
            ram_bank = RAM_BW'(bank_hi);
        end

        rom_addr = {ROM_BW'(rom_bank), A[13:0]};
        rom_cs   = rd_act && !A[15];
        ram_addr = {ram_bank, A[12:0]};
        ram_cs   = !cs_n && ram_en && HAS_RAM && ram_range;
        ram_we   = ram_cs && !wr_n;

        Di = 8'hFF;
        if (rom_cs) begin
            Di = rom_data;
        end else if (ram_cs && rd_act) begin
            Di = ram_data;
        end
    end

endmodule

// File: tb/tb_cart_mapper.sv
// Bench for cart_mapper: two instances (32 and 128 ROM banks) share one bus,
// compared against an arithmetic model of the banking rules.
module tb_cart_mapper;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] A;
    logic [7:0]  Do;
    logic        wr_n, rd_n, cs_n;
    logic [7:0]  rom_data, ram_data;

    logic [7:0]  di_a, di_b;
    logic [18:0] rom_addr_a;
    logic [20:0] rom_addr_b;
    logic        rom_cs_a, rom_cs_b;
    logic [14:0] ram_addr_a, ram_addr_b;
    logic        ram_cs_a, ram_cs_b, ram_we_a, ram_we_b;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state
    int unsigned m_ram_en, m_lo, m_hi, m_mode, m_wrq;

    always #5 clock = ~clock;

    cart_mapper #(.ROM_BANKS(32), .RAM_BANKS(4)) dut_a (
        .clock(clock), .reset_n(reset_n), .A(A), .Do(Do),
        .wr_n(wr_n), .rd_n(rd_n), .cs_n(cs_n),
        .rom_data(rom_data), .ram_data(ram_data),
        .Di(di_a), .rom_addr(rom_addr_a), .rom_cs(rom_cs_a),
        .ram_addr(ram_addr_a), .ram_cs(ram_cs_a), .ram_we(ram_we_a)
    );

    cart_mapper #(.ROM_BANKS(128), .RAM_BANKS(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .A(A), .Do(Do),
        .wr_n(wr_n), .rd_n(rd_n), .cs_n(cs_n),
        .rom_data(rom_data), .ram_data(ram_data),
        .Di(di_b), .rom_addr(rom_addr_b), .rom_cs(rom_cs_b),
        .ram_addr(ram_addr_b), .ram_cs(ram_cs_b), .ram_we(ram_we_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ram_en = 0; m_lo = 0; m_hi = 0; m_mode = 0; m_wrq = 0;
    endtask

    function automatic int unsigned rom_exp(input int unsigned a, input int unsigned nb);
        int unsigned bank;
        if (a < 32'h4000) bank = (m_mode != 0) ? m_hi * 32 : 0;
        else              bank = m_hi * 32 + ((m_lo == 0) ? 1 : m_lo);
        return (bank % nb) * 16384 + (a % 16384);
    endfunction

    function automatic int unsigned ram_exp(input int unsigned a);
        int unsigned bank;
        bank = (m_mode != 0) ? (m_hi % 4) : 0;
        return bank * 8192 + (a % 8192);
    endfunction

    // Compare every output of both instances with the model.
    task automatic check_outputs(input string tag);
        int unsigned a;
        bit rd, wr, in_ram, e_rom_cs, e_ram_cs;
        logic [7:0] e_di;
        a  = 32'(A);
        rd = !cs_n && !rd_n;
        wr = !cs_n && !wr_n;
        in_ram   = (a >= 32'hA000) && (a < 32'hC000);
        e_rom_cs = rd && (a < 32'h8000);
        e_ram_cs = !cs_n && (m_ram_en != 0) && in_ram;
        chk({tag, ".rom_cs_a"}, 32'(rom_cs_a), 32'(e_rom_cs));
        chk({tag, ".rom_cs_b"}, 32'(rom_cs_b), 32'(e_rom_cs));
        if (a < 32'h8000) begin
            chk({tag, ".rom_addr_a"}, 32'(rom_addr_a), rom_exp(a, 32));
            chk({tag, ".rom_addr_b"}, 32'(rom_addr_b), rom_exp(a, 128));
        end
        chk({tag, ".ram_cs_a"}, 32'(ram_cs_a), 32'(e_ram_cs));
        chk({tag, ".ram_cs_b"}, 32'(ram_cs_b), 32'(e_ram_cs));
        chk({tag, ".ram_we_a"}, 32'(ram_we_a), 32'(e_ram_cs && !wr_n));
        chk({tag, ".ram_we_b"}, 32'(ram_we_b), 32'(e_ram_cs && !wr_n));
        if (in_ram) begin
            chk({tag, ".ram_addr_a"}, 32'(ram_addr_a), ram_exp(a));
            chk({tag, ".ram_addr_b"}, 32'(ram_addr_b), ram_exp(a));
        end
        if (!(rd && wr)) begin
            if (e_rom_cs)            e_di = rom_data;
            else if (e_ram_cs && rd) e_di = ram_data;
            else                     e_di = 8'hFF;
            chk({tag, ".di_a"}, 32'(di_a), 32'(e_di));
            chk({tag, ".di_b"}, 32'(di_b), 32'(e_di));
        end
    endtask

    // Advance one clock, updating the model from the pre-edge bus.
    task automatic tick();
        bit commit, wa;
        int unsigned a, d;
        wa     = !cs_n && !wr_n;
        commit = reset_n && wa && (m_wrq == 0);
        a = 32'(A);
        d = 32'(Do);
        @(posedge clock);
        if (!reset_n) begin
            model_reset();
        end else begin
            m_wrq = wa;
            if (commit) begin
                if (a < 32'h2000)      m_ram_en = ((d % 16) == 10) ? 1 : 0;
                else if (a < 32'h4000) m_lo = d % 32;
                else if (a < 32'h6000) m_hi = d % 4;
                else if (a < 32'h8000) m_mode = d % 2;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input bit wr, input bit rd);
        A = a; Do = d;
        wr_n = !wr; rd_n = !rd; cs_n = !(wr || rd);
        rom_data = 8'($urandom);
        ram_data = 8'($urandom);
    endtask

    task automatic idle();
        cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
        drive(a, d, 1'b1, 1'b0);
        tick();
        idle();
        tick();
    endtask

    task automatic read_chk(input logic [15:0] a, input string tag);
        drive(a, 8'h00, 1'b0, 1'b1);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        reset_n = 1'b0;
        A = 16'h0000; Do = 8'h00; rom_data = 8'h00; ram_data = 8'h00;
        idle();
        tick();
        tick();
        check_outputs("reset_idle");
        reset_n = 1'b1;

        // Power-on read of the switchable window
        read_chk(16'h4123, "first_read");
        chk("first_read.addr", 32'(rom_addr_a), 32'h04123);
        chk("first_read.di", 32'(di_a), 32'(rom_data));

        // Bank zero substitution, including masked-to-zero writes
        write_reg(16'h2000, 8'h00);
        read_chk(16'h4000, "lo_zero");
        chk("lo_zero.addr", 32'(rom_addr_a), 32'h04000);
        write_reg(16'h2000, 8'h20);
        read_chk(16'h4000, "lo_20");
        chk("lo_20.addr", 32'(rom_addr_a), 32'h04000);

        // RAM enable / disable
        read_chk(16'hA000, "ram_off");
        chk("ram_off.di", 32'(di_a), 32'hFF);
        write_reg(16'h0000, 8'h0A);
        read_chk(16'hA000, "ram_on");
        chk("ram_on.cs", 32'(ram_cs_a), 32'h1);
        chk("ram_on.di", 32'(di_a), 32'(ram_data));
        drive(16'hA123, 8'h5A, 1'b1, 1'b0);
        #1;
        check_outputs("ram_write");
        tick();
        idle();
        tick();
        write_reg(16'h0000, 8'h0B);
        read_chk(16'hA000, "ram_off2");
        chk("ram_off2.cs", 32'(ram_cs_a), 32'h0);

        // Advanced banking mode on 128 banks
        write_reg(16'h0000, 8'h0A);
        write_reg(16'h4000, 8'h02);
        write_reg(16'h2000, 8'h03);
        write_reg(16'h6000, 8'h01);
        read_chk(16'h4000, "mode1_hi");
        chk("mode1_hi.addr", 32'(rom_addr_b), 32'h10C000);
        read_chk(16'h0000, "mode1_lo");
        chk("mode1_lo.addr", 32'(rom_addr_b), 32'h100000);
        read_chk(16'hA000, "mode1_ram");
        chk("mode1_ram.addr", 32'(ram_addr_b), 32'h4000);
        write_reg(16'h6000, 8'h00);
        read_chk(16'h0000, "mode0_lo");
        chk("mode0_lo.addr", 32'(rom_addr_b), 32'h0);
        read_chk(16'hA000, "mode0_ram");
        chk("mode0_ram.addr", 32'(ram_addr_b), 32'h0);

        // Held strobe with changing data commits once
        drive(16'h2000, 8'h05, 1'b1, 1'b0);
        tick(); tick();
        Do = 8'h06;
        tick(); tick(); tick();
        idle();
        tick();
        read_chk(16'h4000, "held");
        chk("held.addr", 32'(rom_addr_a), 32'h14000);

        // Reset during a held write: discarded, then committed after release
        write_reg(16'h4000, 8'h00);
        drive(16'h2000, 8'h09, 1'b1, 1'b0);
        tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst_held");
        reset_n = 1'b1;
        tick();
        idle();
        tick();
        read_chk(16'h4000, "rst_held_after");
        chk("rst_held_after.addr", 32'(rom_addr_a), 32'h24000);

        // Asynchronous reset clears registers without a clock edge
        write_reg(16'h2000, 8'h07);
        read_chk(16'h4000, "pre_rst");
        chk("pre_rst.addr", 32'(rom_addr_a), 32'h1C000);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        chk("async_rst.addr", 32'(rom_addr_a), 32'h04000);
        idle();
        #1;
        reset_n = 1'b1;
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            logic [7:0]  d;
            bit wr, rd, en;
            a  = 16'($urandom);
            d  = 8'($urandom);
            if ($urandom_range(1, 0) == 1) d[3:0] = 4'hA;
            case ($urandom_range(3, 0))
                0:       a[15:13] = 3'b101;
                1:       a[15]    = 1'b0;
                default: ;
            endcase
            en = ($urandom_range(3, 0) != 0);
            wr = en && ($urandom_range(2, 0) == 0);
            rd = en && ($urandom_range(1, 0) == 1);
            drive(a, d, wr, rd);
            if (!en) idle();
            #1;
            check_outputs("rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
